// File: rtl/inst_fifo_dual.sv
// inst_fifo_dual: dual-issue fetch-to-issue instruction queue; IFIFO_STATS_EN adds stall/empty counters
module inst_fifo_dual #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push_1,
  input  logic                        push_2,
  input  logic [DATA_W-1:0]           push_pc_1,
  input  logic [DATA_W-1:0]           push_inst_1,
  input  logic [DATA_W-1:0]           push_pc_2,
  input  logic [DATA_W-1:0]           push_inst_2,
  output logic                        accept_1,
  output logic                        accept_2,
  input  logic                        pop_1,
  input  logic                        pop_2,
  output logic                        head_valid_1,
  output logic                        head_valid_2,
  output logic [DATA_W-1:0]           head_pc_1,
  output logic [DATA_W-1:0]           head_inst_1,
  output logic [DATA_W-1:0]           head_pc_2,
  output logic [DATA_W-1:0]           head_inst_2,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        almost_full
`ifdef IFIFO_STATS_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 empty_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [AW-1:0] wptr, rptr, wptr_n, rptr_n;
  logic p1, p2;
  // free space is judged from the registered count, so a same-cycle pop never frees a slot for a push
  always_comb begin
    wptr_n       = wptr + AW'(1);
    rptr_n       = rptr + AW'(1);
    accept_1     = push_1 & ~flush & (count != (AW+1)'(DEPTH));
    accept_2     = push_1 & push_2 & ~flush & (count <= (AW+1)'(DEPTH - 2));
    head_valid_1 = count != '0;
    head_valid_2 = count >= (AW+1)'(2);
    p1           = pop_1 & head_valid_1 & ~flush;
    p2           = p1 & pop_2 & head_valid_2;
    head_pc_1    = head_valid_1 ? mem_pc[rptr]     : '0;
    head_inst_1  = head_valid_1 ? mem_inst[rptr]   : '0;
    head_pc_2    = head_valid_2 ? mem_pc[rptr_n]   : '0;
    head_inst_2  = head_valid_2 ? mem_inst[rptr_n] : '0;
    empty        = count == '0;
    almost_full  = count > (AW+1)'(DEPTH - 2);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(accept_1) + AW'(accept_2);
      rptr  <= rptr + AW'(p1) + AW'(p2);
      count <= count + (AW+1)'(accept_1) + (AW+1)'(accept_2) - (AW+1)'(p1) - (AW+1)'(p2);
    end
  end
  always_ff @(posedge clk) begin
    if (accept_1) begin
      mem_pc[wptr]   <= push_pc_1;
      mem_inst[wptr] <= push_inst_1;
    end
    if (accept_2) begin
      mem_pc[wptr_n]   <= push_pc_2;
      mem_inst[wptr_n] <= push_inst_2;
    end
  end
`ifdef IFIFO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      empty_cycles <= '0;
    end else begin
      if (push_1 & ~accept_1 & ~flush & ~&stall_cycles) stall_cycles <= stall_cycles + 32'd1;
      if (empty & ~&empty_cycles) empty_cycles <= empty_cycles + 32'd1;
    end
  end
`endif
endmodule
